// File: rtl/mfcc_frontend.sv
// Multi-channel MFCC front end: pre-emphasis, shared ring buffer with overlapping
// framing, and zero-padded, channel-interleaved frame streaming with valid/ready.
module mfcc_frontend #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          NUM_CHANNELS = 2,
    parameter int          FRAME_SIZE   = 400,
    parameter int          FRAME_MOVE   = 160,
    parameter int          FFT_SIZE     = 512,
    parameter logic [15:0] ALPHA        = 16'd31785,
    localparam int         CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int         FP_W         = $clog2(FFT_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] pcm_in,
    input  logic                                 pcm_ready_i,
    input  logic                                 bypass_preemph_i,
    output logic                                 frame_valid_o,
    input  logic                                 frame_ready_i,
    output logic signed [SAMPLE_WIDTH-1:0]       frame_data_o,
    output logic [CH_W-1:0]                      frame_ch_o,
    output logic [FP_W-1:0]                      frame_ptr_o,
    output logic                                 frame_last_o,
    output logic [15:0]                          frame_count_o,
    output logic                                 overflow_o
);

    localparam int SW         = SAMPLE_WIDTH;
    localparam int PW         = SW + 17;
    localparam int RING_DEPTH = 2 ** $clog2(FRAME_SIZE + FRAME_MOVE);
    localparam int AW         = $clog2(RING_DEPTH);
    localparam int GW         = $clog2(FRAME_SIZE + 1);
    localparam int PNW        = AW + 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic {IDLE, EMIT} state_e;

    function automatic logic signed [SW-1:0] preemph(input logic signed [SW-1:0] x,
                                                     input logic signed [SW-1:0] xp);
        logic signed [PW-1:0] xe, xpe, ae, prod, diff;
        xe   = PW'(x);
        xpe  = PW'(xp);
        ae   = PW'($signed({1'b0, ALPHA}));
        prod = xpe * ae;
        diff = xe - (prod >>> 15);
        if (diff > SAT_MAX)      return SAT_MAX[SW-1:0];
        else if (diff < SAT_MIN) return SAT_MIN[SW-1:0];
        else                     return diff[SW-1:0];
    endfunction

    // ---------------- input side: acceptance, pre-emphasis, ring write ----------------
    logic [AW:0]           wr_ptr_q, wr_ptr_d, oldest_q, oldest_d, stored;
    logic                  accept;
    logic signed [SW-1:0]  x_prev_q [NUM_CHANNELS];
    logic signed [SW-1:0]  x_prev_d [NUM_CHANNELS];
    logic signed [SW-1:0]  pre_q    [NUM_CHANNELS];
    logic signed [SW-1:0]  pre_d    [NUM_CHANNELS];
    logic                  pre_vld_q, pre_vld_d;
    logic [AW-1:0]         pre_addr_q, pre_addr_d;
    logic signed [SW-1:0]  ring_q   [NUM_CHANNELS][RING_DEPTH];
    logic                  overflow_q, overflow_d;

    // Occupancy counts reserved slots (including the sample still in the pipeline),
    // so an accepted sample can never land on a slot of the frame being read.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stored     = wr_ptr_q - oldest_q;
        accept     = pcm_ready_i && (stored != (AW+1)'(RING_DEPTH));
        wr_ptr_d   = wr_ptr_q + (AW+1)'(accept);
        overflow_d = overflow_q | (pcm_ready_i & ~accept);
        pre_vld_d  = accept;
        pre_addr_d = wr_ptr_q[AW-1:0];
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            x_prev_d[c] = x_prev_q[c];
            pre_d[c]    = pre_q[c];
            if (accept) begin
                pre_d[c]    = bypass_preemph_i ? $signed(pcm_in[c*SW +: SW])
                                               : preemph($signed(pcm_in[c*SW +: SW]), x_prev_q[c]);
                x_prev_d[c] = $signed(pcm_in[c*SW +: SW]);
            end
        end
    end

    // ---------------- frame generation ----------------
    logic [GW-1:0] gen_cnt_q, gen_cnt_d;
    logic          primed_q, primed_d;
    logic          new_frame;

    always_comb begin
        gen_cnt_d = gen_cnt_q;
        primed_d  = primed_q;
        new_frame = 1'b0;
        if (pre_vld_q) begin
            if (gen_cnt_q == (primed_q ? GW'(FRAME_MOVE - 1) : GW'(FRAME_SIZE - 1))) begin
                new_frame = 1'b1;
                gen_cnt_d = '0;
                primed_d  = 1'b1;
            end else begin
                gen_cnt_d = gen_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- emission ----------------
    state_e                state_q, state_d;
    logic [PNW-1:0]        pending_q, pending_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic signed [SW-1:0]  data_q, data_d;
    logic [CH_W-1:0]       ch_q, ch_d, ld_ch;
    logic [FP_W-1:0]       ptr_q, ptr_d, ld_ptr;
    logic [15:0]           count_q, count_d;
    logic                  fire, last_fire, ld;
    logic [AW-1:0]         ld_start, rd_addr;

    assign fire      = valid_q && frame_ready_i;
    assign last_fire = fire && last_q;

    always_comb begin
        pending_d = pending_q + PNW'(new_frame) - PNW'(last_fire);
        oldest_d  = last_fire ? oldest_q + (AW+1)'(FRAME_MOVE) : oldest_q;
        count_d   = count_q + 16'(last_fire);
    end

    // The output register doubles as the registered ring read: a new word is
    // loaded only when the slot is empty or its current word is being taken.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ch_d     = ch_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        ld       = 1'b0;
        ld_ch    = '0;
        ld_ptr   = '0;
        ld_start = oldest_q[AW-1:0];
        rd_addr  = '0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    ld      = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (fire) begin
                    if (last_q) begin
                        if (pending_q > PNW'(1) || new_frame) begin
                            ld       = 1'b1;
                            ld_start = oldest_q[AW-1:0] + AW'(FRAME_MOVE);
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        ld = 1'b1;
                        if (ptr_q == FP_W'(FFT_SIZE - 1)) begin
                            ld_ch  = ch_q + 1'b1;
                            ld_ptr = '0;
                        end else begin
                            ld_ch  = ch_q;
                            ld_ptr = ptr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (ld) begin
            rd_addr = ld_start + AW'(ld_ptr);
            valid_d = 1'b1;
            ch_d    = ld_ch;
            ptr_d   = ld_ptr;
            last_d  = (ld_ch == CH_W'(NUM_CHANNELS - 1)) && (ld_ptr == FP_W'(FFT_SIZE - 1));
            data_d  = (32'(ld_ptr) < 32'(FRAME_SIZE)) ? ring_q[ld_ch][rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            oldest_q   <= '0;
            pre_vld_q  <= 1'b0;
            pre_addr_q <= '0;
            overflow_q <= 1'b0;
            gen_cnt_q  <= '0;
            primed_q   <= 1'b0;
            state_q    <= IDLE;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                x_prev_q[c] <= '0;
                pre_q[c]    <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            oldest_q   <= oldest_d;
            pre_vld_q  <= pre_vld_d;
            pre_addr_q <= pre_addr_d;
            overflow_q <= overflow_d;
            gen_cnt_q  <= gen_cnt_d;
            primed_q   <= primed_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            count_q    <= count_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                x_prev_q[c] <= x_prev_d[c];
                pre_q[c]    <= pre_d[c];
            end
        end
    end

    // NOTE: the ring is storage, not control state; it is never read before being
    // written, so it carries no reset and maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (pre_vld_q) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ring_q[c][pre_addr_q] <= pre_q[c];
            end
        end
    end

    assign frame_valid_o = valid_q;
    assign frame_data_o  = data_q;
    assign frame_ch_o    = ch_q;
    assign frame_ptr_o   = ptr_q;
    assign frame_last_o  = last_q;
    assign frame_count_o = count_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_mfcc_frontend.sv
// Bench for mfcc_frontend: a sample-history model predicts every emitted word,
// frame count and overflow flag; directed scenarios pin the model with literals.
module tb_mfcc_frontend;

    localparam int    SW    = 16;
    localparam int    NC    = 2;
    localparam int    FS    = 8;
    localparam int    FM    = 4;
    localparam int    FFT   = 16;
    localparam int    RD    = 16;
    localparam longint ALPHA_V = 31785;

    logic              clk;
    logic              rst_n;
    logic [NC*SW-1:0]  pcm_in;
    logic              pcm_ready_i;
    logic              bypass_preemph_i;
    logic              frame_valid_o;
    logic              frame_ready_i;
    logic signed [SW-1:0] frame_data_o;
    logic [0:0]        frame_ch_o;
    logic [3:0]        frame_ptr_o;
    logic              frame_last_o;
    logic [15:0]       frame_count_o;
    logic              overflow_o;

    mfcc_frontend #(
        .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC), .FRAME_SIZE(FS),
        .FRAME_MOVE(FM), .FFT_SIZE(FFT), .ALPHA(16'd31785)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pcm_in(pcm_in), .pcm_ready_i(pcm_ready_i),
        .bypass_preemph_i(bypass_preemph_i), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .frame_data_o(frame_data_o),
        .frame_ch_o(frame_ch_o), .frame_ptr_o(frame_ptr_o), .frame_last_o(frame_last_o),
        .frame_count_o(frame_count_o), .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        longint data;
        int     ch;
        int     ptr;
        bit     last;
    } word_t;

    longint yhist [NC][$];
    longint xprev [NC];
    int     accepted;
    int     done_frames;
    int     m_count;
    bit     m_ovf;
    word_t  expq [$];
    longint log_q [$];

    bit     prev_stall;
    longint prev_data;
    int     prev_ch, prev_ptr;
    bit     prev_last;
    bit     rand_ready = 1'b0;

    function automatic longint preemph_model(input longint x, input longint xp);
        longint y;
        y = x - ((ALPHA_V * xp) >>> 15);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic void push_frame(input int start);
        word_t w;
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < FFT; p++) begin
                w.data = (p < FS) ? yhist[c][start + p] : 0;
                w.ch   = c;
                w.ptr  = p;
                w.last = (c == NC - 1) && (p == FFT - 1);
                expq.push_back(w);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                yhist[c].delete();
                xprev[c] = 0;
            end
            accepted    = 0;
            done_frames = 0;
            m_count     = 0;
            m_ovf       = 1'b0;
            expq.delete();
            prev_stall  = 1'b0;
        end else begin
            word_t w;
            check("frame_count", longint'(frame_count_o), m_count);
            check("overflow", longint'(overflow_o), longint'(m_ovf));
            if (prev_stall) begin
                check("stall_valid", longint'(frame_valid_o), 1);
                check("stall_data", longint'(frame_data_o), prev_data);
                check("stall_ch", longint'(frame_ch_o), prev_ch);
                check("stall_ptr", longint'(frame_ptr_o), prev_ptr);
                check("stall_last", longint'(frame_last_o), longint'(prev_last));
            end
            // Input side first: acceptance is decided against the pre-edge occupancy.
            if (pcm_ready_i) begin
                if (accepted - FM * done_frames >= RD) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int c = 0; c < NC; c++) begin
                        longint x;
                        x = longint'($signed(pcm_in[c*SW +: SW]));
                        yhist[c].push_back(bypass_preemph_i ? x : preemph_model(x, xprev[c]));
                        xprev[c] = x;
                    end
                    accepted++;
                    if (accepted == FS || (accepted > FS && (accepted - FS) % FM == 0))
                        push_frame(accepted - FS);
                end
            end
            if (frame_valid_o && frame_ready_i) begin
                log_q.push_back(longint'(frame_data_o));
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got data %0d ch %0d ptr %0d want none",
                             frame_data_o, frame_ch_o, frame_ptr_o);
                end else begin
                    w = expq.pop_front();
                    check("word_data", longint'(frame_data_o), w.data);
                    check("word_ch", longint'(frame_ch_o), w.ch);
                    check("word_ptr", longint'(frame_ptr_o), w.ptr);
                    check("word_last", longint'(frame_last_o), longint'(w.last));
                    if (w.last) begin
                        m_count = (m_count + 1) % 65536;
                        done_frames++;
                    end
                end
            end
            prev_stall = frame_valid_o && !frame_ready_i;
            prev_data  = longint'(frame_data_o);
            prev_ch    = int'(frame_ch_o);
            prev_ptr   = int'(frame_ptr_o);
            prev_last  = frame_last_o;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) frame_ready_i = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send(input logic [SW-1:0] s0, input logic [SW-1:0] s1, input logic byp);
        pcm_in           = {s1, s0};
        bypass_preemph_i = byp;
        pcm_ready_i      = 1'b1;
        @(posedge clk); #1;
        pcm_ready_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || frame_valid_o) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_bound"}, longint'(n < 2000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // 32 words of one frame starting at log offset base: ch0 then ch1, 8 data + 8 zeros each.
    task automatic check_frame(input string name, input int base, input longint b0, input longint b1);
        longint exp;
        for (int i = 0; i < 32; i++) begin
            if (i < 8)                exp = b0 + i;
            else if (i >= 16 && i < 24) exp = b1 + (i - 16);
            else                      exp = 0;
            check($sformatf("%s_w%0d", name, i), (base + i < log_q.size()) ? log_q[base + i] : -99999, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, longint'(frame_valid_o), 0);
        check({name, "_data"},  longint'(frame_data_o), 0);
        check({name, "_ch"},    longint'(frame_ch_o), 0);
        check({name, "_ptr"},   longint'(frame_ptr_o), 0);
        check({name, "_last"},  longint'(frame_last_o), 0);
        check({name, "_count"}, longint'(frame_count_o), 0);
        check({name, "_ovf"},   longint'(overflow_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst_n            = 1'b0;
        pcm_in           = '0;
        pcm_ready_i      = 1'b0;
        bypass_preemph_i = 1'b0;
        frame_ready_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Model pins: 1000 - floor(31785*1000/32768) = 1000 - 970 = 30.
        check("model_first", preemph_model(32767, 0), 32767);
        check("model_const", preemph_model(1000, 1000), 30);
        check("model_sat",   preemph_model(-32768, 32767), -32768);
        check("model_neg",   preemph_model(-32768, -32768), -983);

        // 1: pre-emphasis
        frame_ready_i = 1'b1;
        for (int n = 0; n < 8; n++)
            send(16'd1000, (n == 0) ? 16'sh7fff : 16'sh8000, 1'b0);
        drain("s1");
        check("s1_ch0_first", log_q[0], 1000);
        check("s1_ch0_second", log_q[1], 30);
        check("s1_ch0_last", log_q[7], 30);
        check("s1_ch1_first", log_q[16], 32767);
        check("s1_ch1_sat", log_q[17], -32768);
        check("s1_ch1_third", log_q[18], -983);

        // 2: first frame and padding
        do_reset();
        frame_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) send(16'(n), 16'(100 + n), 1'b1);
        drain("s2");
        check("s2_words", log_q.size(), 32);
        check_frame("s2", 0, 0, 100);
        check("s2_count", longint'(frame_count_o), 1);

        // 3: overlap
        log_q.delete();
        for (int n = 8; n < 12; n++) send(16'(n), 16'(100 + n), 1'b1);
        drain("s3");
        check("s3_words", log_q.size(), 32);
        check_frame("s3", 0, 4, 104);
        check("s3_count", longint'(frame_count_o), 2);

        // 4: back-pressure
        do_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 8; n++) send(16'(n), 16'(100 + n), 1'b1);
        drain("s4");
        rand_ready = 1'b0;
        @(posedge clk); #1;
        check("s4_words", log_q.size(), 32);
        check_frame("s4", 0, 0, 100);
        check("s4_count", longint'(frame_count_o), 1);

        // 5: overflow
        do_reset();
        frame_ready_i = 1'b0;
        for (int n = 0; n < 17; n++) send(16'(n), 16'(100 + n), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("s5_ovf_set", longint'(overflow_o), 1);
        frame_ready_i = 1'b1;
        drain("s5");
        check("s5_words", log_q.size(), 96);
        check_frame("s5_f0", 0, 0, 100);
        check_frame("s5_f1", 32, 4, 104);
        check_frame("s5_f2", 64, 8, 108);
        check("s5_count", longint'(frame_count_o), 3);
        check("s5_ovf_sticky", longint'(overflow_o), 1);

        // 6: reset mid-frame
        do_reset();
        frame_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) send(16'(n), 16'(100 + n), 1'b1);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (frame_valid_o && frame_ch_o == 1'b0 && frame_ptr_o == 4'd5) found = 1'b1;
        end
        check("s6_reach_ptr5", longint'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s6_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_q.delete();
        for (int n = 0; n < 8; n++) send(16'(n), 16'(100 + n), 1'b1);
        drain("s6");
        check("s6_words", log_q.size(), 32);
        check_frame("s6", 0, 0, 100);
        check("s6_count", longint'(frame_count_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
